// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time imem loader.
// Frame FSM and UART receiver state encodings.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_WORD,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = 8 * LEN_BYTES;

endpackage

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver with 2-flop synchronizer.
// Emits a one-cycle byte_valid or frame_err after the stop-bit sample.
module uart_rx
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF =
    CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        baud_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (baud_q == HALF) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_q == FULL) begin
          baud_d  = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (baud_q == FULL) begin
          baud_d  = '0;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/imem_loader.sv
// Boot image loader: UART frame -> imem writes, holds CPU in reset
// until a checksum-verified image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int ADDR_W       = 8,
  parameter int IMEM_WORDS   = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  ld_state_e         state_q, state_d;
  logic [IDX_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       asm_q, asm_d;
  logic [7:0]        chk_q, chk_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [IDX_W-1:0]  n_len;

  assign n_len = {byte_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    chk_d   = chk_q;
    bcnt_d  = bcnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_LEN_LO: begin
        if (byte_valid) begin
          len_d   = {8'h00, byte_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (byte_valid) begin
          len_d = n_len;
          if (n_len == '0)
            state_d = S_CHECK;
          else if (32'(n_len) > IMEM_WORDS)
            state_d = S_ERROR;
          else
            state_d = S_WORD;
        end
      end
      S_WORD: begin
        if (byte_valid) begin
          asm_d  = {byte_data, asm_q[31:8]};
          chk_d  = chk_q ^ byte_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'(WORD_BYTES - 1)) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            addr_d  = ADDR_W'(idx_q);
            wdata_d = asm_d;
          end
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_d == len_q) ? S_CHECK : S_WORD;
      end
      S_CHECK: begin
        if (byte_valid)
          state_d = (byte_data == chk_q) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: ;
      default: state_d = S_ERROR;
    endcase
    // A bad stop bit aborts the load unless already terminal.
    if (frame_err && state_q != S_DONE && state_q != S_ERROR) begin
      state_d = S_ERROR;
      we_d    = 1'b0;
    end
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERROR);
    cpu_rst_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_LEN_LO;
      len_q     <= '0;
      idx_q     <= '0;
      asm_q     <= '0;
      chk_q     <= '0;
      bcnt_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      chk_q     <= chk_d;
      bcnt_q    <= bcnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_rst_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: directed UART frames,
// expected imem writes queued and popped by an independent monitor.
module tb_imem_loader;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  imem_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (8),
    .IMEM_WORDS  (256)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  bv_cnt = 0;

  logic [7:0] img [0:10] = '{
    8'h02, 8'h00,
    8'h13, 8'h00, 8'h00, 8'h00,
    8'h93, 8'h00, 8'h10, 8'h00,
    8'h90
  };

  always @(posedge clk)
    if (dut.u_rx.byte_valid) bv_cnt <= bv_cnt + 1;

  always @(negedge clk) begin
    if (!reset && imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h",
                 imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (imem_addr !== e.a || imem_wdata !== e.d) begin
          errors++;
          $display("FAIL write got %h/%h want %h/%h",
                   imem_addr, imem_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop);
    rx = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(CPB);
    end
    rx = stop;
    wait_clk(CPB);
    rx = 1'b1;
    if (!stop) wait_clk(CPB);
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i <= to; i++) send_byte(img[i], 1'b1);
  endtask

  task automatic push_img;
    wr_t w;
    w.a = 8'd0; w.d = 32'h0000_0013; exp_q.push_back(w);
    w.a = 8'd1; w.d = 32'h0010_0093; exp_q.push_back(w);
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    rx = 1'b1;
    wait_clk(4);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    reset = 1'b0;
    wait_clk(2);
  endtask

  task automatic end_state(input string name,
                           input logic d,
                           input logic e,
                           input logic c);
    wait_clk(4);
    chk({name, "_done"}, 32'(done), 32'(d));
    chk({name, "_error"}, 32'(error), 32'(e));
    chk({name, "_cpu_reset"}, 32'(cpu_reset), 32'(c));
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int bv0;

    apply_reset();
    push_img();
    send_range(0, 9);
    wait_clk(2);
    chk("pre_chk_cpu_reset", 32'(cpu_reset), 1);
    chk("pre_chk_done", 32'(done), 0);
    send_byte(img[10], 1'b1);
    end_state("good", 1'b1, 1'b0, 1'b0);
    chk("hold_addr", 32'(imem_addr), 1);
    chk("hold_wdata", imem_wdata, 32'h0010_0093);

    apply_reset();
    push_img();
    send_range(0, 9);
    send_byte(8'h91, 1'b1);
    end_state("badchk", 1'b0, 1'b1, 1'b1);

    apply_reset();
    send_byte(8'h01, 1'b1);
    wait_clk(2);
    chk("len_lo_error", 32'(error), 0);
    send_byte(8'h01, 1'b1);
    end_state("toolong", 1'b0, 1'b1, 1'b1);

    apply_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    end_state("empty", 1'b1, 1'b0, 1'b0);

    apply_reset();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b0);
    wait_clk(2);
    chk("ferr_error", 32'(error), 1);
    send_range(0, 10);
    end_state("ferr", 1'b0, 1'b1, 1'b1);

    apply_reset();
    bv0 = bv_cnt;
    rx = 1'b0;
    wait_clk(CPB / 4);
    rx = 1'b1;
    wait_clk(3 * CPB);
    chk("glitch_bytes", bv_cnt - bv0, 0);
    chk("glitch_error", 32'(error), 0);
    push_img();
    send_range(0, 10);
    end_state("post_glitch", 1'b1, 1'b0, 1'b0);

    apply_reset();
    send_range(0, 4);
    apply_reset();
    push_img();
    send_range(0, 10);
    end_state("midreset", 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
